// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings used by the response multiplexer and its
// default subordinate.
//   - htrans_t    : manager transfer type encodings
//   - HRESP_*     : subordinate response encodings
//   - def_state_t : default-subordinate error FSM states
// ---------------------------------------------------------------------------
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } def_state_t;

endpackage : ahb_pkg

// File: rtl/ahb_default_sub.sv
// ---------------------------------------------------------------------------
// ahb_default_sub
// Default subordinate: answers transfers that no single subordinate owns with
// the two-cycle AHB ERROR response, and counts those responses.
//
// Ports:
//   i_hclk      bus clock, rising edge
//   i_hresetn   asynchronous active-low reset
//   i_start     current address phase is active and has an invalid select
//   i_hready    muxed bus HREADY (address phase is sampled when high)
//   o_hready    default-subordinate HREADYOUT (low only in ERR1)
//   o_hresp     default-subordinate HRESP (ERROR in ERR1/ERR2)
//   o_err_cnt   saturating count of ERROR responses issued
// ---------------------------------------------------------------------------
module ahb_default_sub
    import ahb_pkg::*;
#(
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     i_hclk,
    input  logic                     i_hresetn,
    input  logic                     i_start,
    input  logic                     i_hready,
    output logic                     o_hready,
    output logic [1:0]               o_hresp,
    output logic [ERR_CNT_WIDTH-1:0] o_err_cnt
);

    def_state_t               r_state;
    def_state_t               w_state_next;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
    logic                     w_start;
    logic                     w_enter_err1;
    logic                     w_cnt_full;

    // An error response only begins when the address phase is actually sampled.
    assign w_start      = i_start & i_hready;
    assign w_enter_err1 = (w_state_next == DS_ERR1);
    assign w_cnt_full   = &r_err_cnt;

    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_state <= DS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ERR1 never loops onto itself, so every cycle whose next state is ERR1
    // is a fresh ERR1 entry.
    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_err_cnt <= '0;
        end else if (w_enter_err1 && !w_cnt_full) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_hready     = 1'b1;
        o_hresp      = HRESP_OKAY;
        case (r_state)
            DS_IDLE: begin
                if (w_start) begin
                    w_state_next = DS_ERR1;
                end
            end
            DS_ERR1: begin
                o_hready     = 1'b0;
                o_hresp      = HRESP_ERROR;
                w_state_next = DS_ERR2;
            end
            DS_ERR2: begin
                // HREADY is high here, so the next address phase is sampled
                // now and may chain straight into another error pair.
                o_hresp      = HRESP_ERROR;
                w_state_next = w_start ? DS_ERR1 : DS_IDLE;
            end
            default: begin
                w_state_next = DS_IDLE;
            end
        endcase
    end

    assign o_err_cnt = r_err_cnt;

endmodule : ahb_default_sub

// File: rtl/ahb_resp_mux_n.sv
// ---------------------------------------------------------------------------
// ahb_resp_mux_n
// AHB-Lite subordinate-to-manager response multiplexer with an integrated
// default subordinate. Records which subordinate owns the data phase
// (updated only when the muxed HREADY is high) and returns that owner's
// HRDATA/HRESP/HREADY. Unmapped or multiply-selected active transfers get
// the two-cycle ERROR response from ahb_default_sub.
//
// Parameters:
//   NO_OF_SUBORDINATES  number of subordinates N (1..16)
//   DATA_WIDTH          read data width
//   ERR_CNT_WIDTH       error counter width
//
// Ports:
//   HCLK      bus clock
//   HRESETn   asynchronous active-low reset
//   HSEL      decoder selects, one bit per subordinate (address phase)
//   HTRANS    manager transfer type (address phase)
//   HREADY_S  HREADYOUT of each subordinate
//   HRESP_S   HRESP of subordinate i at [2i+1:2i]
//   HRDATA_S  HRDATA of subordinate i at [DATA_WIDTH*i +: DATA_WIDTH]
//   HRDATA    muxed read data
//   HRESP     muxed response
//   HREADY    muxed ready, also the HREADY seen by all subordinates
//   ERR_CNT   saturating count of default-subordinate ERROR responses
// ---------------------------------------------------------------------------
module ahb_resp_mux_n
    import ahb_pkg::*;
#(
    parameter int NO_OF_SUBORDINATES = 4,
    parameter int DATA_WIDTH         = 32,
    parameter int ERR_CNT_WIDTH      = 16
) (
    input  logic                                     HCLK,
    input  logic                                     HRESETn,
    input  logic [NO_OF_SUBORDINATES-1:0]            HSEL,
    input  logic [1:0]                               HTRANS,
    input  logic [NO_OF_SUBORDINATES-1:0]            HREADY_S,
    input  logic [2*NO_OF_SUBORDINATES-1:0]          HRESP_S,
    input  logic [NO_OF_SUBORDINATES*DATA_WIDTH-1:0] HRDATA_S,
    output logic [DATA_WIDTH-1:0]                    HRDATA,
    output logic [1:0]                               HRESP,
    output logic                                     HREADY,
    output logic [ERR_CNT_WIDTH-1:0]                 ERR_CNT
);

    localparam int N = NO_OF_SUBORDINATES;

    // Data-phase ownership
    logic [N-1:0] r_dp_sel;
    logic         r_dp_err;

    // Address-phase classification
    htrans_t      w_htrans;
    logic         w_active;
    logic [N-1:0] w_hsel_minus1;
    logic         w_hsel_onehot;
    logic         w_start_err;

    // Owner mux
    logic [DATA_WIDTH-1:0] w_rdata_masked [N];
    logic [1:0]            w_resp_masked  [N];
    logic [N-1:0]          w_ready_masked;
    logic [DATA_WIDTH-1:0] w_owner_rdata;
    logic [1:0]            w_owner_resp;
    logic                  w_owner_ready;

    // Default subordinate
    logic       w_def_hready;
    logic [1:0] w_def_hresp;

    logic                  w_hready;
    logic [1:0]            w_hresp;
    logic [DATA_WIDTH-1:0] w_hrdata;

    // -----------------------------------------------------------------------
    // Address-phase classification
    // -----------------------------------------------------------------------
    assign w_htrans = htrans_t'(HTRANS);
    assign w_active = (w_htrans == HTRANS_NONSEQ) || (w_htrans == HTRANS_SEQ);

    // x & (x-1) clears the lowest set bit: zero result with a non-zero x
    // means exactly one select is asserted.
    assign w_hsel_minus1 = HSEL - N'(1);
    assign w_hsel_onehot = (|HSEL) && !(|(HSEL & w_hsel_minus1));

    // Idle/busy transfers to nowhere complete as zero-wait OKAY, so only
    // active transfers can start an error response.
    assign w_start_err = !w_hsel_onehot && w_active;

    // -----------------------------------------------------------------------
    // Data-phase owner register: only advances when the current data phase
    // completes (muxed HREADY high).
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dp_sel <= '0;
            r_dp_err <= 1'b0;
        end else if (w_hready) begin
            if (w_hsel_onehot) begin
                r_dp_sel <= HSEL;
                r_dp_err <= 1'b0;
            end else begin
                r_dp_sel <= '0;
                r_dp_err <= w_active;
            end
        end
    end

    // -----------------------------------------------------------------------
    // One-hot AND-OR mux across subordinates
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign w_rdata_masked[gi] = {DATA_WIDTH{r_dp_sel[gi]}}
                                        & HRDATA_S[DATA_WIDTH*gi +: DATA_WIDTH];
            assign w_resp_masked[gi]  = {2{r_dp_sel[gi]}} & HRESP_S[2*gi +: 2];
            assign w_ready_masked[gi] = r_dp_sel[gi] & HREADY_S[gi];
        end
    endgenerate

    always_comb begin
        w_owner_rdata = '0;
        w_owner_resp  = '0;
        for (int i = 0; i < N; i++) begin
            w_owner_rdata = w_owner_rdata | w_rdata_masked[i];
            w_owner_resp  = w_owner_resp  | w_resp_masked[i];
        end
        w_owner_ready = |w_ready_masked;
    end

    // -----------------------------------------------------------------------
    // Default subordinate
    // -----------------------------------------------------------------------
    ahb_default_sub #(
        .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
    ) u_default_sub (
        .i_hclk    (HCLK),
        .i_hresetn (HRESETn),
        .i_start   (w_start_err),
        .i_hready  (w_hready),
        .o_hready  (w_def_hready),
        .o_hresp   (w_def_hresp),
        .o_err_cnt (ERR_CNT)
    );

    // -----------------------------------------------------------------------
    // Response select. All terms depend only on registers or subordinate
    // outputs, so after an asynchronous reset the bus is ready/OKAY at once.
    // -----------------------------------------------------------------------
    always_comb begin
        w_hready = 1'b1;
        w_hresp  = HRESP_OKAY;
        w_hrdata = '0;
        if (|r_dp_sel) begin
            w_hready = w_owner_ready;
            w_hresp  = w_owner_resp;
            w_hrdata = w_owner_rdata;
        end else if (r_dp_err) begin
            w_hready = w_def_hready;
            w_hresp  = w_def_hresp;
        end
    end

    assign HREADY = w_hready;
    assign HRESP  = w_hresp;
    assign HRDATA = w_hrdata;

endmodule : ahb_resp_mux_n

// File: tb/tb_ahb_resp_mux_n.sv
module tb_ahb_resp_mux_n;
    import ahb_pkg::*;

    logic         HCLK;
    logic         HRESETn;
    logic [3:0]   HSEL;
    logic [1:0]   HTRANS;
    logic [3:0]   HREADY_S;
    logic [7:0]   HRESP_S;
    logic [127:0] HRDATA_S;
    logic [31:0]  HRDATA;
    logic [1:0]   HRESP;
    logic         HREADY;
    logic [1:0]   ERR_CNT;

    int n_checks = 0;
    int n_errors = 0;

    // Fixed per-subordinate read data: S3, S2, S1, S0
    assign HRDATA_S = {32'h3333BEEF, 32'h22222222, 32'hA5A5A5A5, 32'h00C0FFEE};

    ahb_resp_mux_n #(
        .NO_OF_SUBORDINATES(4),
        .DATA_WIDTH        (32),
        .ERR_CNT_WIDTH     (2)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HSEL     (HSEL),
        .HTRANS   (HTRANS),
        .HREADY_S (HREADY_S),
        .HRESP_S  (HRESP_S),
        .HRDATA_S (HRDATA_S),
        .HRDATA   (HRDATA),
        .HRESP    (HRESP),
        .HREADY   (HREADY),
        .ERR_CNT  (ERR_CNT)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [3:0]  hsel;
        logic [1:0]  htrans;
        logic [3:0]  hready_s;
        logic [7:0]  hresp_s;
        logic        exp_hready;
        logic [1:0]  exp_hresp;
        logic [31:0] exp_hrdata;
        logic [1:0]  exp_cnt;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [3:0] hsel, input logic [1:0] htrans,
                                input logic [3:0] rdy_s, input logic [7:0] resp_s,
                                input logic e_rdy, input logic [1:0] e_resp,
                                input logic [31:0] e_data, input logic [1:0] e_cnt);
        vec_t v;
        v.hsel       = hsel;
        v.htrans     = htrans;
        v.hready_s   = rdy_s;
        v.hresp_s    = resp_s;
        v.exp_hready = e_rdy;
        v.exp_hresp  = e_resp;
        v.exp_hrdata = e_data;
        v.exp_cnt    = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic e_rdy, input logic [1:0] e_resp,
                             input logic [31:0] e_data, input logic [1:0] e_cnt);
        check({tag, ".hready"}, {31'd0, HREADY}, {31'd0, e_rdy});
        check({tag, ".hresp"},  {30'd0, HRESP},  {30'd0, e_resp});
        check({tag, ".hrdata"}, HRDATA,          e_data);
        check({tag, ".errcnt"}, {30'd0, ERR_CNT}, {30'd0, e_cnt});
        $display("%s: hsel=%b htrans=%b hready_s=%b -> hready=%b hresp=%b hrdata=%h err_cnt=%0d",
                 tag, HSEL, HTRANS, HREADY_S, HREADY, HRESP, HRDATA, ERR_CNT);
    endtask

    localparam logic [1:0] ID = HTRANS_IDLE;
    localparam logic [1:0] BU = HTRANS_BUSY;
    localparam logic [1:0] NS = HTRANS_NONSEQ;
    localparam logic [1:0] SQ = HTRANS_SEQ;

    initial begin
        // Each row describes one bus cycle: inputs driven during the cycle and
        // the response expected before the edge that closes it.
        // S1 read, two wait states
        vecs[0]  = mk(4'b0010, NS, 4'b1111, 8'h00, 1'b1, 2'b00, 32'h0,        2'd0);
        vecs[1]  = mk(4'b0000, ID, 4'b1101, 8'h00, 1'b0, 2'b00, 32'hA5A5A5A5, 2'd0);
        vecs[2]  = mk(4'b0000, ID, 4'b1101, 8'h00, 1'b0, 2'b00, 32'hA5A5A5A5, 2'd0);
        vecs[3]  = mk(4'b0000, ID, 4'b1111, 8'h00, 1'b1, 2'b00, 32'hA5A5A5A5, 2'd0);
        // Unmapped NONSEQ -> error pair; address during ERR1 ignored
        vecs[4]  = mk(4'b0000, NS, 4'b1111, 8'h00, 1'b1, 2'b00, 32'h0,        2'd0);
        vecs[5]  = mk(4'b0110, NS, 4'b1111, 8'h00, 1'b0, 2'b01, 32'h0,        2'd1);
        // Multi-select sampled in ERR2 -> back-to-back error pair
        vecs[6]  = mk(4'b0110, NS, 4'b1111, 8'h00, 1'b1, 2'b01, 32'h0,        2'd1);
        vecs[7]  = mk(4'b0000, ID, 4'b1111, 8'h00, 1'b0, 2'b01, 32'h0,        2'd2);
        // Unmapped SEQ in ERR2 -> third pair
        vecs[8]  = mk(4'b0000, SQ, 4'b1111, 8'h00, 1'b1, 2'b01, 32'h0,        2'd2);
        vecs[9]  = mk(4'b0000, ID, 4'b1111, 8'h00, 1'b0, 2'b01, 32'h0,        2'd3);
        // Fourth pair: counter saturates at 3
        vecs[10] = mk(4'b0000, NS, 4'b1111, 8'h00, 1'b1, 2'b01, 32'h0,        2'd3);
        vecs[11] = mk(4'b0000, ID, 4'b1111, 8'h00, 1'b0, 2'b01, 32'h0,        2'd3);
        vecs[12] = mk(4'b0000, ID, 4'b1111, 8'h00, 1'b1, 2'b01, 32'h0,        2'd3);
        // BUSY to a multi-select: zero-wait OKAY, no count
        vecs[13] = mk(4'b1100, BU, 4'b1111, 8'h00, 1'b1, 2'b00, 32'h0,        2'd3);
        // S0 stalls 3 cycles while HSEL points at S3
        vecs[14] = mk(4'b0001, NS, 4'b1111, 8'h00, 1'b1, 2'b00, 32'h0,        2'd3);
        vecs[15] = mk(4'b1000, NS, 4'b1110, 8'h00, 1'b0, 2'b00, 32'h00C0FFEE, 2'd3);
        vecs[16] = mk(4'b1000, NS, 4'b1110, 8'h00, 1'b0, 2'b00, 32'h00C0FFEE, 2'd3);
        vecs[17] = mk(4'b1000, NS, 4'b1110, 8'h00, 1'b0, 2'b00, 32'h00C0FFEE, 2'd3);
        vecs[18] = mk(4'b1000, NS, 4'b1111, 8'h00, 1'b1, 2'b00, 32'h00C0FFEE, 2'd3);
        // S3 owns now and returns its own ERROR: passed through, not counted
        vecs[19] = mk(4'b0100, NS, 4'b0111, 8'h40, 1'b0, 2'b01, 32'h3333BEEF, 2'd3);
        vecs[20] = mk(4'b0100, NS, 4'b1111, 8'h40, 1'b1, 2'b01, 32'h3333BEEF, 2'd3);
        // S2 owns; a non-owner's low HREADYOUT must not stall the bus
        vecs[21] = mk(4'b0000, ID, 4'b0111, 8'h00, 1'b1, 2'b00, 32'h22222222, 2'd3);
        // Unmapped NONSEQ, leading into the reset-during-ERR1 sequence
        vecs[22] = mk(4'b0000, NS, 4'b1111, 8'h00, 1'b1, 2'b00, 32'h0,        2'd3);

        HRESETn  = 1'b0;
        HSEL     = 4'b0000;
        HTRANS   = HTRANS_IDLE;
        HREADY_S = 4'b1111;
        HRESP_S  = 8'h00;

        #12;
        check_bus("reset", 1'b1, 2'b00, 32'h0, 2'd0);
        #1 HRESETn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge HCLK);
            #1;
            HSEL     = vecs[i].hsel;
            HTRANS   = vecs[i].htrans;
            HREADY_S = vecs[i].hready_s;
            HRESP_S  = vecs[i].hresp_s;
            @(negedge HCLK);
            check_bus($sformatf("vec%0d", i), vecs[i].exp_hready, vecs[i].exp_hresp,
                      vecs[i].exp_hrdata, vecs[i].exp_cnt);
        end

        // Asynchronous reset in the middle of ERR1
        @(posedge HCLK);
        #1;
        HSEL   = 4'b0000;
        HTRANS = HTRANS_IDLE;
        #2;
        check_bus("err1_before_rst", 1'b0, 2'b01, 32'h0, 2'd3);
        HRESETn = 1'b0;
        #1;
        check_bus("err1_during_rst", 1'b1, 2'b00, 32'h0, 2'd0);
        #1 HRESETn = 1'b1;

        // Asynchronous reset in the middle of a subordinate wait state
        @(posedge HCLK);
        #1;
        HSEL   = 4'b0010;
        HTRANS = HTRANS_NONSEQ;
        @(posedge HCLK);
        #1;
        HSEL     = 4'b0000;
        HTRANS   = HTRANS_IDLE;
        HREADY_S = 4'b1101;
        #2;
        check_bus("wait_before_rst", 1'b0, 2'b00, 32'hA5A5A5A5, 2'd0);
        HRESETn = 1'b0;
        #1;
        check_bus("wait_during_rst", 1'b1, 2'b00, 32'h0, 2'd0);
        #1 HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        check_bus("after_rst", 1'b1, 2'b00, 32'h0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ahb_resp_mux_n
